// File: rtl/program_counter_16bit.sv
// Program counter with a small return-address stack.
// Supports clear, return, call, load and increment, in that priority order.

module incrementor_16bit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
endmodule

module program_counter_16bit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pc,
    output logic             wrap,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             err
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] stk [STACK_DEPTH];
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pc_next_seq;
    logic             pc_cout;
    logic [PW-1:0]    top_idx;
    logic             do_push;

    incrementor_16bit #(.WIDTH(WIDTH)) u_inc (
        .a    (pc),
        .sum  (pc_next_seq),
        .cout (pc_cout)
    );

    assign stk_full  = (count == CW'(STACK_DEPTH));
    assign stk_empty = (count == '0);
    // Wraps modulo depth, so a full stack still points at the last slot.
    assign top_idx   = count[PW-1:0] - PW'(1);
    assign do_push   = !clr && !ret && call && !stk_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            count <= '0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                pc    <= '0;
                count <= '0;
                err   <= 1'b0;
            end else if (ret) begin
                if (!stk_empty) begin
                    pc    <= stk[top_idx];
                    count <= count - CW'(1);
                end else begin
                    err <= 1'b1;
                end
            end else if (call) begin
                if (!stk_full) begin
                    pc    <= din;
                    count <= count + CW'(1);
                end else begin
                    err <= 1'b1;
                end
            end else if (load) begin
                pc <= din;
            end else if (inc) begin
                pc   <= pc_next_seq;
                wrap <= pc_cout;
            end
        end
    end

    // Stack storage needs no reset: slots at or above count are never read.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            stk[count[PW-1:0]] <= pc_next_seq;
        end
    end
endmodule

// File: tb/tb_program_counter_16bit.sv
// Directed bench for program_counter_16bit: reset, wrap, priority, nested calls,
// overflow, underflow, call at FFFF and asynchronous reset mid-operation.

module tb_program_counter_16bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] pc;
    logic        wrap, stk_full, stk_empty, err;

    int errors = 0;
    int checks = 0;

    program_counter_16bit #(.WIDTH(16), .STACK_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .din       (din),
        .pc        (pc),
        .wrap      (wrap),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply one action for exactly one rising edge, then sample 1ns later.
    task automatic op(input logic c_clr, input logic c_ret, input logic c_call,
                      input logic c_load, input logic c_inc, input logic [15:0] d);
        clr = c_clr; ret = c_ret; call = c_call; load = c_load; inc = c_inc; din = d;
        @(posedge clk);
        #1;
        clr = 1'b0; ret = 1'b0; call = 1'b0; load = 1'b0; inc = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic e_full, input logic e_empty,
                             input logic e_err);
        chk({tag, "_full"},  {15'd0, stk_full},  {15'd0, e_full});
        chk({tag, "_empty"}, {15'd0, stk_empty}, {15'd0, e_empty});
        chk({tag, "_err"},   {15'd0, err},       {15'd0, e_err});
    endtask

    initial begin
        // Reset pulsed low between edges must act without a clock.
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        op(0, 0, 0, 1, 0, 16'h7777);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk_flags("rst", 1'b0, 1'b1, 1'b0);
        chk("rst_wrap", {15'd0, wrap}, 16'd0);
        #2 rst_n = 1'b1;

        // Wrap pulse
        op(0, 0, 0, 1, 0, 16'hFFFF);
        chk("load_ffff", pc, 16'hFFFF);
        op(0, 0, 0, 0, 1, 16'h0000);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_hi", {15'd0, wrap}, 16'd1);
        op(0, 0, 0, 0, 1, 16'h0000);
        chk("inc_pc", pc, 16'h0001);
        chk("wrap_lo", {15'd0, wrap}, 16'd0);

        // Priority: load beats inc, clr beats load
        op(0, 0, 0, 1, 0, 16'h1234);
        op(0, 0, 0, 1, 1, 16'hABCD);
        chk("load_over_inc", pc, 16'hABCD);
        op(1, 0, 0, 1, 0, 16'h5555);
        chk("clr_over_load", pc, 16'h0000);

        // Nested calls
        op(0, 0, 0, 1, 0, 16'h0010);
        op(0, 0, 1, 0, 0, 16'h0100);
        chk("call1", pc, 16'h0100);
        chk_flags("call1", 1'b0, 1'b0, 1'b0);
        op(0, 0, 1, 0, 0, 16'h0200);
        chk("call2", pc, 16'h0200);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("ret1", pc, 16'h0101);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("ret2", pc, 16'h0011);
        chk_flags("ret2", 1'b0, 1'b1, 1'b0);

        // call+ret on an empty stack: ret wins and underflows
        op(0, 1, 1, 0, 0, 16'h0900);
        chk("callret_empty_pc", pc, 16'h0011);
        chk_flags("callret_empty", 1'b0, 1'b1, 1'b1);
        op(1, 0, 0, 0, 0, 16'h0000);
        chk("clr_pc", pc, 16'h0000);
        chk_flags("clr", 1'b0, 1'b1, 1'b0);

        // Overflow
        op(0, 0, 0, 1, 0, 16'h0F00);
        op(0, 0, 1, 0, 0, 16'h1000);
        op(0, 0, 1, 0, 0, 16'h2000);
        op(0, 0, 1, 0, 0, 16'h3000);
        chk_flags("three_calls", 1'b0, 1'b0, 1'b0);
        op(0, 0, 1, 0, 0, 16'h4000);
        chk("fourth_call", pc, 16'h4000);
        chk_flags("full", 1'b1, 1'b0, 1'b0);
        op(0, 0, 1, 0, 0, 16'h5000);
        chk("ovf_pc", pc, 16'h4000);
        chk_flags("ovf", 1'b1, 1'b0, 1'b1);
        // err is sticky but does not block; call+ret performs ret only
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("ovf_ret1", pc, 16'h3001);
        chk_flags("ovf_ret1", 1'b0, 1'b0, 1'b1);
        op(0, 1, 1, 0, 0, 16'h6000);
        chk("callret_pc", pc, 16'h2001);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("ovf_ret3", pc, 16'h1001);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("ovf_ret4", pc, 16'h0F01);
        chk_flags("ovf_ret4", 1'b0, 1'b1, 1'b1);

        // Underflow after clearing err
        op(1, 0, 0, 0, 0, 16'h0000);
        op(0, 0, 0, 1, 0, 16'h0F01);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("udf_pc", pc, 16'h0F01);
        chk_flags("udf", 1'b0, 1'b1, 1'b1);
        op(0, 0, 0, 0, 1, 16'h0000);
        chk("udf_inc", pc, 16'h0F02);
        chk("udf_err_sticky", {15'd0, err}, 16'd1);
        op(1, 0, 0, 0, 0, 16'h0000);
        chk_flags("udf_clr", 1'b0, 1'b1, 1'b0);

        // Call from FFFF pushes 0000 and does not raise wrap
        op(0, 0, 0, 1, 0, 16'hFFFF);
        op(0, 0, 1, 0, 0, 16'h0700);
        chk("call_ffff_pc", pc, 16'h0700);
        chk("call_ffff_wrap", {15'd0, wrap}, 16'd0);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("ret_to_0000", pc, 16'h0000);

        // Async reset with a call pending; stack contents are discarded
        op(0, 0, 0, 1, 0, 16'h2222);
        op(0, 0, 1, 0, 0, 16'h3333);
        chk("pre_rst_pc", pc, 16'h3333);
        call = 1'b1; din = 16'h4444;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 16'h0000);
        chk_flags("midrst", 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_held_pc", pc, 16'h0000);
        chk_flags("rst_held", 1'b0, 1'b1, 1'b0);
        call = 1'b0;
        rst_n = 1'b1;
        op(0, 0, 0, 0, 1, 16'h0000);
        chk("post_rst_inc", pc, 16'h0001);
        op(0, 1, 0, 0, 0, 16'h0000);
        chk("post_rst_ret_pc", pc, 16'h0001);
        chk_flags("post_rst_ret", 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_counter_16bit.md
PROGRAM_COUNTER_16BIT -- requirements
Module: program_counter_16bit

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, the width of pc and din.
REQ-002 SHALL provide parameter STACK_DEPTH, default 4, the number of return-address stack entries (power of two, at least 2).
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL provide port clr, input, 1, synchronous clear.
REQ-006 SHALL provide port load, input, 1, load pc from din.
REQ-007 SHALL provide port inc, input, 1, advance pc by one.
REQ-008 SHALL provide port call, input, 1, push pc+1 and jump to din.
REQ-009 SHALL provide port ret, input, 1, pop the return address into pc.
REQ-010 SHALL provide port din, input, WIDTH, the jump/load target.
REQ-011 SHALL provide port pc, output, WIDTH, the registered program counter.
REQ-012 SHALL provide port wrap, output, 1, a one-cycle pulse flagging an increment from all-ones to zero.
REQ-013 SHALL provide port stk_full, output, 1, the stack holds STACK_DEPTH entries.
REQ-014 SHALL provide port stk_empty, output, 1, the stack holds 0 entries.
REQ-015 SHALL provide port err, output, 1, a sticky stack overflow/underflow flag.

Function
REQ-016 pc+1 SHALL be computed by an instance of incrementor_16bit (ports a, sum, cout); with WIDTH=16, sum SHALL be the increment value and cout the wrap indication.
REQ-017 Per-edge priority SHALL be clr > ret > call > load > inc > hold; exactly one action takes effect per edge.
REQ-018 clr SHALL set pc=0, empty the stack, and clear err and wrap.
REQ-019 ret with stack not empty SHALL set pc to the top entry and decrement the count.
REQ-020 ret with stack empty SHALL hold pc and set err.
REQ-021 call with stack not full SHALL write the incrementor sum to the stack, increment the count, and set pc=din.
REQ-022 A call with pc=FFFF SHALL push 0000.
REQ-023 call with stack full SHALL hold pc, leave the stack unchanged, and set err.
REQ-024 load SHALL set pc=din.
REQ-025 inc SHALL set pc to the incrementor sum, so FFFF wraps to 0000.
REQ-026 wrap SHALL be registered and high for exactly the one cycle following an edge at which inc was the winning action and cout=1; otherwise wrap SHALL be 0.
REQ-027 stk_full and stk_empty SHALL be decoded combinationally from the registered count.
REQ-028 Entries above the count SHALL have no observable effect.
REQ-029 err SHALL remain 1 until clr or rst_n; once set, err SHALL NOT block further operations.
REQ-030 Simultaneous call and ret SHALL perform ret only, per REQ-017.
REQ-031 Simultaneous load and inc SHALL perform load only, per REQ-017.
REQ-032 Operation latency SHALL be one edge: the new pc is visible after the edge at which the action was sampled.
REQ-033 The block SHALL contain no combinational path from inputs to pc.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock edge, force pc=0, stack count=0, wrap=0 and err=0, with stk_empty=1 and stk_full=0.
REQ-035 While rst_n=0, all other inputs SHALL be ignored.
REQ-036 Deassertion of rst_n SHALL take effect at the next rising edge, so the first action is sampled on the first edge with rst_n=1.
REQ-037 Reset asserted mid-operation (pending call/ret) SHALL discard that operation; stack contents are not preserved.

Verification
REQ-038 The bench SHALL cover reset: rst_n pulsed low between clock edges -> pc=0000, stk_empty=1, err=0 without a clock edge.
REQ-039 The bench SHALL cover wrap: load din=FFFF, then inc -> pc=0000 and wrap=1 for one cycle; a further inc -> pc=0001, wrap=0.
REQ-040 The bench SHALL cover priority: pc=1234 with load=1, inc=1, din=ABCD -> pc=ABCD; then clr=1 and load=1 together -> pc=0000.
REQ-041 The bench SHALL cover nested calls: from pc=0010, call din=0100, then call din=0200 -> pc=0200; then ret -> pc=0101; then ret -> pc=0011, stk_empty=1.
REQ-042 The bench SHALL cover overflow: STACK_DEPTH+1 consecutive calls -> stk_full=1 after STACK_DEPTH calls; the last call leaves pc unchanged and sets err=1.
REQ-043 The bench SHALL cover underflow: ret on an empty stack -> pc held and err=1; subsequent inc still advances pc; clr -> err=0.
